// File: rtl/weight_dispatcher.sv
// weight_dispatcher: reads a row range from the weight buffer and streams it to the PE array through a credit-checked FIFO
module weight_dispatcher #(
  parameter int DATA_W = 4096,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W:0]   cmd_len,
  output logic              wb_req,
  output logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_rdata,
  output logic              row_valid,
  output logic [DATA_W-1:0] row_data,
  output logic              row_last,
  input  logic              row_ready,
  output logic              busy,
  output logic              done
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(RD_LAT + 1);
  localparam logic [ADDR_W:0] ONE = 1;
  localparam logic [PW+1:0] DEPTH_C = (PW+2)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0] iss_cnt, acc_cnt;
  logic [RD_LAT-1:0] sr_v, sr_l;
  logic [IW-1:0] inflight;
  logic [PW:0] wptr, rptr, count;
  logic [PW+1:0] occ;
  logic [DATA_W:0] mem [FIFO_DEPTH];
  logic [DATA_W:0] head;
  logic push, pop, drained, accept;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE  ? (cmd_valid ? (cmd_len == '0 ? DRAIN : ISSUE) : IDLE) :
              state == ISSUE ? (wb_req && iss_cnt == ONE ? DRAIN : ISSUE) :
                               (drained ? IDLE : DRAIN);
  always_comb begin
    cmd_ready = rst_n && state == IDLE;
    busy = state != IDLE;
    done = state == DRAIN && drained;
    wb_req = state == ISSUE && occ < DEPTH_C;
  end
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + IW'(sr_v[i]);
  end
  assign accept = cmd_ready && cmd_valid;
  assign count = wptr - rptr;
  assign occ = (PW+2)'(inflight) + (PW+2)'(count);
  assign push = sr_v[RD_LAT-1];
  assign row_valid = count != '0;
  assign pop = row_valid && row_ready;
  assign head = mem[rptr[PW-1:0]];
  assign row_data = row_valid ? head[DATA_W-1:0] : '0;
  assign row_last = row_valid && head[DATA_W];
  assign drained = acc_cnt == '0 && inflight == '0 && count == '0;
  assign wb_addr = addr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr <= '0;
      iss_cnt <= '0;
      acc_cnt <= '0;
      sr_v <= '0;
      sr_l <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (accept) begin
        addr <= cmd_base;
        iss_cnt <= cmd_len;
      end else if (wb_req) begin
        addr <= addr + 1'b1;
        iss_cnt <= iss_cnt - 1'b1;
      end
      acc_cnt <= accept ? cmd_len : acc_cnt - (ADDR_W+1)'(pop);
      sr_v <= {sr_v[RD_LAT-2:0], wb_req};
      sr_l <= {sr_l[RD_LAT-2:0], wb_req && iss_cnt == ONE};
      wptr <= wptr + (PW+1)'(push);
      rptr <= rptr + (PW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wptr[PW-1:0]] <= {sr_l[RD_LAT-1], wb_rdata};
endmodule

// File: tb/tb_weight_dispatcher.sv
// tb_weight_dispatcher: scoreboard bench with a fixed-latency weight-buffer model
module tb_weight_dispatcher;
  localparam int DW = 4096, AW = 8, DEPTH = 8, LAT = 3;
  logic clk = 0, rst_n = 0, cmd_valid = 0, row_ready = 1;
  logic cmd_ready, wb_req, row_valid, row_last, busy, done;
  logic [AW-1:0] cmd_base = '0, wb_addr, ea;
  logic [AW:0] cmd_len = '0;
  logic [DW-1:0] wb_rdata, row_data;
  logic [DW:0] hold_d, er;
  logic hold_v = 0;
  int checks = 0, passed = 0, cyc = 0, t = 0, occ = 0;
  int req_n = 0, row_n = 0, done_n = 0, first_req = -1, last_req = -1, first_row = -1, done_cyc = -1;
  logic [AW-1:0] exp_addr_q[$];
  logic [DW:0] exp_row_q[$];
  logic [LAT-1:0] bv = '0;
  logic [AW-1:0] ba [LAT];
  weight_dispatcher #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .wb_req(wb_req), .wb_addr(wb_addr),
    .wb_rdata(wb_rdata), .row_valid(row_valid), .row_data(row_data), .row_last(row_last),
    .row_ready(row_ready), .busy(busy), .done(done)
  );
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {128{8'hA5, a, ~a, 8'h3C}};
  endfunction
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    bv <= {bv[LAT-2:0], wb_req};
    ba[0] <= wb_addr;
    for (int i = 1; i < LAT; i++) ba[i] <= ba[i-1];
  end
  assign wb_rdata = bv[LAT-1] ? pat(ba[LAT-1]) : '0;
  always @(negedge clk) begin
    if (!rst_n) hold_v = 0;
    else begin
      if (wb_req) begin
        req_n++;
        occ++;
        last_req = cyc;
        if (first_req < 0) first_req = cyc;
        checks++;
        if (exp_addr_q.size() == 0) $display("FAIL wb_addr: unexpected request addr %0h", wb_addr);
        else begin
          ea = exp_addr_q.pop_front();
          if (wb_addr !== ea) $display("FAIL wb_addr: got %0h want %0h", wb_addr, ea);
          else passed++;
        end
        if (occ > DEPTH) begin
          checks++;
          $display("FAIL credit: outstanding %0d exceeds %0d", occ, DEPTH);
        end
      end
      if (row_valid && first_row < 0) first_row = cyc;
      if (hold_v) begin
        checks++;
        if ({row_valid, row_last, row_data} !== {1'b1, hold_d}) $display("FAIL hold: row changed while stalled, valid=%b", row_valid);
        else passed++;
      end
      if (row_valid && row_ready) begin
        row_n++;
        occ--;
        checks++;
        if (exp_row_q.size() == 0) $display("FAIL row: unexpected row last=%b addr=%0h", row_last, row_data[23:16]);
        else begin
          er = exp_row_q.pop_front();
          if ({row_last, row_data} !== er)
            $display("FAIL row: got last=%b addr=%0h want last=%b addr=%0h", row_last, row_data[23:16], er[DW], er[23:16]);
          else passed++;
        end
      end
      hold_v = row_valid && !row_ready;
      hold_d = {row_last, row_data};
      if (done) begin
        done_n++;
        done_cyc = cyc;
      end
    end
  end
  task automatic send(input logic [AW-1:0] base, input int len);
    logic [AW-1:0] a;
    for (int i = 0; i < len; i++) begin
      a = base + AW'(i);
      exp_addr_q.push_back(a);
      exp_row_q.push_back({i == len - 1, pat(a)});
    end
    req_n = 0; row_n = 0; done_n = 0;
    first_req = -1; last_req = -1; first_row = -1; done_cyc = -1;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_base = base; cmd_len = (AW+1)'(len); t = cyc;
    checks++;
    if (cmd_ready !== 1'b1) $display("FAIL cmd_ready: got %b want 1", cmd_ready); else passed++;
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask
  task automatic wait_done(input bit rnd);
    int n = 0;
    while (done_n == 0 && n < 2000) begin
      @(posedge clk); #1;
      if (rnd) row_ready = 1'($urandom_range(0, 1));
      n++;
    end
    checks++;
    if (done_n == 0) $display("FAIL done: timeout, got %0d pulses want 1", done_n); else passed++;
    row_ready = 1;
  endtask
  task automatic test_reset();
    #1;
    checks++;
    if ({cmd_ready, wb_req, wb_addr, row_valid, row_last, busy, done} !== '0)
      $display("FAIL reset_ctl: got %b want 0", {cmd_ready, wb_req, wb_addr, row_valid, row_last, busy, done});
    else passed++;
    checks++;
    if (row_data !== '0) $display("FAIL reset_data: got nonzero want 0"); else passed++;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    @(posedge clk); #1;
    checks++;
    if ({cmd_ready, busy} !== 2'b10) $display("FAIL post_reset: got %b want 10", {cmd_ready, busy}); else passed++;
  endtask
  task automatic test_single();
    send(8'h10, 1);
    wait_done(0);
    checks++;
    if (first_req !== t + 1) $display("FAIL single_req: got %0d want %0d", first_req, t + 1); else passed++;
    checks++;
    if (first_row !== t + 5) $display("FAIL single_row: got %0d want %0d", first_row, t + 5); else passed++;
    checks++;
    if (done_cyc !== t + 6) $display("FAIL single_done: got %0d want %0d", done_cyc, t + 6); else passed++;
    checks++;
    if ({req_n, row_n} !== {32'd1, 32'd1}) $display("FAIL single_count: got %0d/%0d want 1/1", req_n, row_n); else passed++;
  endtask
  task automatic test_back_to_back();
    send(8'h00, 16);
    wait_done(0);
    checks++;
    if (first_req !== t + 1 || last_req !== t + 16)
      $display("FAIL b2b_req: got %0d..%0d want %0d..%0d", first_req, last_req, t + 1, t + 16);
    else passed++;
    checks++;
    if (first_row !== t + 5) $display("FAIL b2b_row: got %0d want %0d", first_row, t + 5); else passed++;
    checks++;
    if (done_cyc !== t + 16 + LAT + 2) $display("FAIL b2b_done: got %0d want %0d", done_cyc, t + 16 + LAT + 2); else passed++;
    checks++;
    if ({req_n, row_n} !== {32'd16, 32'd16}) $display("FAIL b2b_count: got %0d/%0d want 16/16", req_n, row_n); else passed++;
  endtask
  task automatic test_backpressure();
    row_ready = 0;
    send(8'h80, 16);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (req_n !== 8) $display("FAIL bp_stall: got %0d requests want 8", req_n); else passed++;
    checks++;
    if (row_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", row_valid); else passed++;
    wait_done(1);
    checks++;
    if ({req_n, row_n} !== {32'd16, 32'd16}) $display("FAIL bp_count: got %0d/%0d want 16/16", req_n, row_n); else passed++;
  endtask
  task automatic test_wrap();
    send(8'd254, 4);
    wait_done(0);
    checks++;
    if ({req_n, row_n} !== {32'd4, 32'd4}) $display("FAIL wrap_count: got %0d/%0d want 4/4", req_n, row_n); else passed++;
  endtask
  task automatic test_len0();
    send(8'h33, 0);
    wait_done(0);
    checks++;
    if (done_cyc !== t + 1) $display("FAIL len0_done: got %0d want %0d", done_cyc, t + 1); else passed++;
    checks++;
    if (cmd_ready !== 1'b1) $display("FAIL len0_ready: got %b want 1", cmd_ready); else passed++;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({req_n, done_n} !== {32'd0, 32'd1}) $display("FAIL len0_count: got req %0d done %0d want 0/1", req_n, done_n); else passed++;
  endtask
  task automatic test_reset_mid();
    int n = 0;
    send(8'h00, 16);
    while (req_n < 5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    #1 rst_n = 0;
    #1;
    checks++;
    if ({cmd_ready, wb_req, wb_addr, row_valid, row_last, busy, done} !== '0)
      $display("FAIL mid_reset: got %b want 0", {cmd_ready, wb_req, wb_addr, row_valid, row_last, busy, done});
    else passed++;
    checks++;
    if (row_data !== '0) $display("FAIL mid_reset_data: got nonzero want 0"); else passed++;
    exp_addr_q.delete();
    exp_row_q.delete();
    occ = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    send(8'h40, 2);
    wait_done(0);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if ({req_n, row_n, done_n} !== {32'd2, 32'd2, 32'd1})
      $display("FAIL mid_after: got req %0d rows %0d done %0d want 2/2/1", req_n, row_n, done_n);
    else passed++;
    checks++;
    if (exp_row_q.size() != 0) $display("FAIL mid_left: got %0d rows pending want 0", exp_row_q.size()); else passed++;
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_len0();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
